// File: rtl/seq_multiplier_n.sv
// Signed/unsigned add-shift multiplier: B (loaded) times S (captured at start) into {A,B}, 2*WIDTH bits.
// Latency: start edge, then WIDTH iteration edges, then one settle edge into DONE (Done after edge WIDTH+1).
// No backpressure: Run/Done handshake; Run must drop in DONE before another start is accepted.
module seq_multiplier_n #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic             SignedMode,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic             r_x;
    logic             r_mode;
    // Set by the last iteration; the following COMPUTE cycle only settles before DONE.
    logic             r_fin;
    logic [CW-1:0]    r_cnt;

    logic             w_start;
    logic             w_load;
    logic             w_last;
    logic [WIDTH:0]   w_aext;
    logic [WIDTH:0]   w_mext;
    logic [WIDTH:0]   w_addend;
    logic [WIDTH:0]   w_sum;

    assign w_load  = (r_state == ST_IDLE) && ClearA_LoadB;
    // Load wins over Run when both are high in IDLE.
    assign w_start = (r_state == ST_IDLE) && Run && !ClearA_LoadB;
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    // One iteration of the adder at WIDTH+1 bits; signed mode subtracts on the sign-bit iteration.
    always_comb begin
        w_aext   = r_mode ? {r_a[WIDTH-1], r_a} : {1'b0, r_a};
        w_mext   = r_mode ? {r_m[WIDTH-1], r_m} : {1'b0, r_m};
        w_addend = r_b[0] ? w_mext : '0;
        if (r_mode && w_last) begin
            w_sum = w_aext - w_addend;
        end else begin
            w_sum = w_aext + w_addend;
        end
    end

    // Next-state logic for the IDLE/COMPUTE/DONE controller.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (r_fin) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!Run) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath: load, start capture, and one shift-add step per COMPUTE cycle until r_fin.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_m    <= '0;
            r_x    <= 1'b0;
            r_mode <= 1'b0;
            r_fin  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_a <= '0;
            r_x <= 1'b0;
            r_b <= S;
        end else if (w_start) begin
            // B is kept so the previous low half can be chained as the new multiplier.
            r_a    <= '0;
            r_x    <= 1'b0;
            r_m    <= S;
            r_mode <= SignedMode;
            r_cnt  <= '0;
            r_fin  <= 1'b0;
        end else if ((r_state == ST_COMPUTE) && !r_fin) begin
            r_x   <= r_mode ? w_sum[WIDTH] : 1'b0;
            r_a   <= w_sum[WIDTH:1];
            r_b   <= {w_sum[0], r_b[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
            r_fin <= w_last;
        end
    end

    assign Aval = r_a;
    assign Bval = r_b;
    assign X    = r_x;
    assign Busy = (r_state == ST_COMPUTE) && !r_fin;
    assign Done = (r_state == ST_DONE);

endmodule

// File: tb/tb_seq_multiplier_n.sv
module tb_seq_multiplier_n;

    logic        clk;
    logic        rst;

    logic        run_8, ld_8, sm_8;
    logic [7:0]  s_8, a_8, b_8;
    logic        x_8, busy_8, done_8;

    logic        run_16, ld_16, sm_16;
    logic [15:0] s_16, a_16, b_16;
    logic        x_16, busy_16, done_16;

    int checks   = 0;
    int failures = 0;

    seq_multiplier_n #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst), .Run(run_8), .ClearA_LoadB(ld_8), .SignedMode(sm_8),
        .S(s_8), .Aval(a_8), .Bval(b_8), .X(x_8), .Busy(busy_8), .Done(done_8)
    );

    seq_multiplier_n #(.WIDTH(16)) dut16 (
        .Clk(clk), .Reset(rst), .Run(run_16), .ClearA_LoadB(ld_16), .SignedMode(sm_16),
        .S(s_16), .Aval(a_16), .Bval(b_16), .X(x_16), .Busy(busy_16), .Done(done_16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer multiplication of w-bit operands, truncated to 2w bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] b, input logic [31:0] m,
                                            input logic sgn, input int w);
        longint    pb, pm, p;
        logic [63:0] mask;
        pb = longint'({32'd0, b});
        pm = longint'({32'd0, m});
        if (sgn && b[w-1]) pb = pb - (longint'(1) << w);
        if (sgn && m[w-1]) pm = pm - (longint'(1) << w);
        p    = pb * pm;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load8(input logic [7:0] v);
        ld_8 = 1'b1; run_8 = 1'b0; s_8 = v;
        tick();
        ld_8 = 1'b0;
        chk("load8_b", b_8, v);
    endtask

    // Start edge, then wait (bounded) for Done; edges counted from the start edge.
    task automatic start8(input logic [7:0] m, input logic sgn, input bit perturb,
                          output int edges, output int busy_n);
        s_8 = m; sm_8 = sgn; run_8 = 1'b1;
        tick();
        edges = 0; busy_n = 0;
        while (done_8 !== 1'b1 && edges < 60) begin
            if (busy_8 === 1'b1) busy_n++;
            if (perturb && edges == 3) begin
                s_8  = ~m;
                sm_8 = ~sgn;
            end
            tick();
            edges++;
        end
    endtask

    task automatic check8(input logic [7:0] b, input logic [7:0] m, input logic sgn,
                          input int edges, input int busy_n);
        logic [63:0] p;
        p = ref_mul({24'd0, b}, {24'd0, m}, sgn, 8);
        chk("lat8_done_edge", edges, 9);
        chk("lat8_busy_cycles", busy_n, 8);
        chk("prod8_a", a_8, p[15:8]);
        chk("prod8_b", b_8, p[7:0]);
        chk("prod8_x", x_8, sgn ? p[15] : 1'b0);
    endtask

    task automatic release8();
        run_8 = 1'b0;
        tick();
        chk("done8_drop", done_8, 1'b0);
    endtask

    task automatic op8(input logic [7:0] b, input logic [7:0] m, input logic sgn, input bit perturb);
        int e, bn;
        load8(b);
        start8(m, sgn, perturb, e, bn);
        check8(b, m, sgn, e, bn);
        release8();
    endtask

    initial begin
        logic [7:0]  cur_b, sa, sb, ra, rb;
        logic [63:0] p;
        int          e, bn;

        rst = 1'b1;
        run_8 = 0; ld_8 = 0; sm_8 = 0; s_8 = '0;
        run_16 = 0; ld_16 = 0; sm_16 = 0; s_16 = '0;
        #23;
        chk("rst_a", a_8, 8'h00);
        chk("rst_b", b_8, 8'h00);
        chk("rst_x", x_8, 1'b0);
        chk("rst_busy", busy_8, 1'b0);
        chk("rst_done", done_8, 1'b0);
        rst = 1'b0;
        tick();

        // Directed products from the usage examples.
        op8(8'd7,   8'd59,  1'b1, 1'b0);
        op8(8'd7,   8'hC5,  1'b1, 1'b0);
        op8(8'hF9,  8'hC5,  1'b1, 1'b0);
        op8(8'hF9,  8'hC5,  1'b0, 1'b0);
        op8(8'h80,  8'h80,  1'b1, 1'b0);
        op8(8'hFF,  8'hFF,  1'b0, 1'b0);
        op8(8'h80,  8'h7F,  1'b1, 1'b0);

        // Chain: low half of each product becomes the next multiplier.
        load8(8'hFE);
        cur_b = 8'hFE;
        for (int k = 0; k < 4; k++) begin
            start8(8'hFE, 1'b1, 1'b0, e, bn);
            check8(cur_b, 8'hFE, 1'b1, e, bn);
            p     = ref_mul({24'd0, cur_b}, 32'h0000_00FE, 1'b1, 8);
            cur_b = p[7:0];
            release8();
        end

        // Run held high in DONE: no restart, outputs stable.
        load8(8'd13);
        start8(8'd11, 1'b0, 1'b0, e, bn);
        check8(8'd13, 8'd11, 1'b0, e, bn);
        ra = a_8; rb = b_8;
        for (int k = 0; k < 3; k++) tick();
        chk("hold_done", done_8, 1'b1);
        chk("hold_busy", busy_8, 1'b0);
        chk("hold_a", a_8, ra);
        chk("hold_b", b_8, rb);
        release8();

        // Load and Run together: load wins, start happens on the following edge.
        ld_8 = 1'b1; run_8 = 1'b1; s_8 = 8'h9A; sm_8 = 1'b1;
        tick();
        ld_8 = 1'b0;
        chk("ldrun_b", b_8, 8'h9A);
        chk("ldrun_busy", busy_8, 1'b0);
        start8(8'h37, 1'b1, 1'b0, e, bn);
        check8(8'h9A, 8'h37, 1'b1, e, bn);
        release8();

        // Operand and mode changes during COMPUTE are ignored.
        op8(8'hB3, 8'h5C, 1'b1, 1'b1);
        op8(8'hB3, 8'h5C, 1'b0, 1'b1);

        // Asynchronous reset in the middle of iteration 4.
        load8(8'h55);
        s_8 = 8'h66; sm_8 = 1'b1; run_8 = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) tick();
        chk("mid_busy_pre", busy_8, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_a", a_8, 8'h00);
        chk("arst_b", b_8, 8'h00);
        chk("arst_x", x_8, 1'b0);
        chk("arst_busy", busy_8, 1'b0);
        chk("arst_done", done_8, 1'b0);
        #1 rst = 1'b0;
        run_8 = 1'b0;
        tick();
        chk("arst_idle_busy", busy_8, 1'b0);
        op8(8'h55, 8'h66, 1'b1, 1'b0);

        // Random operands and modes.
        for (int k = 0; k < 20; k++) begin
            sa = 8'($urandom);
            sb = 8'($urandom);
            op8(sa, sb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // WIDTH=16: 300 * -5 with latency check.
        ld_16 = 1'b1; s_16 = 16'd300;
        tick();
        ld_16 = 1'b0;
        chk("load16_b", b_16, 16'd300);
        s_16 = 16'hFFFB; sm_16 = 1'b1; run_16 = 1'b1;
        tick();
        e = 0; bn = 0;
        while (done_16 !== 1'b1 && e < 100) begin
            if (busy_16 === 1'b1) bn++;
            tick();
            e++;
        end
        p = ref_mul(32'd300, 32'h0000_FFFB, 1'b1, 16);
        chk("lat16_done_edge", e, 17);
        chk("lat16_busy_cycles", bn, 16);
        chk("prod16", {a_16, b_16}, p[31:0]);
        chk("prod16_x", x_16, p[31]);
        run_16 = 1'b0;
        tick();
        chk("done16_drop", done_16, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_multiplier_n.md
# seq_multiplier_n

Parametrised signed/unsigned sequential add-shift multiplier. It is the next generation of the 8-bit lab multiplier datapath and keeps the same switch-driven load/run usage model. A WIDTH-bit multiplier is loaded into B. A WIDTH-bit multiplicand is captured from S when Run starts. The 2·WIDTH-bit product is produced in {A,B} after WIDTH compute cycles, so a result can be chained into the next multiplication. Hex/LED display decode is a separate block and reads Aval, Bval and X.

## Interface
- WIDTH, default 8: operand width in bits. Legal range is 4..32.
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Run  in  1  active-high start request; edge-qualified by the FSM.
- ClearA_LoadB  in  1  active-high; in IDLE: A←0, X←0, B←S.
- SignedMode  in  1  1 = two's-complement operands, 0 = unsigned; sampled at start.
- S  in  WIDTH  switch operand: the multiplier on load, the multiplicand on start.
- Aval  out  WIDTH  upper half of the product (register A).
- Bval  out  WIDTH  lower half of the product / multiplier (register B).
- X  out  1  sign-extension bit; equals Aval[WIDTH-1] after a signed operation and 0 after an unsigned one.
- Busy  out  1  high in COMPUTE.
- Done  out  1  high in DONE.

## Operation
- State registers: X, A[WIDTH], B[WIDTH], M[WIDTH] (captured multiplicand), mode bit, cnt[$clog2(WIDTH)], FSM.
- FSM states are IDLE, COMPUTE, DONE. Transitions:
  - IDLE→COMPUTE when Run=1 and ClearA_LoadB=0.
  - COMPUTE→DONE after WIDTH iterations.
  - DONE→IDLE when Run=0.
- Start edge (IDLE, Run=1): A←0, X←0, M←S, mode←SignedMode, cnt←0. B is kept, which allows chaining.
- Each COMPUTE cycle performs one iteration, with sum computed at WIDTH+1 bits:
  - Signed mode: the addend is {M[W-1],M} if B[0]=1, otherwise 0. On the last iteration (cnt=WIDTH-1) with B[0]=1 it is the negated (subtracted) {M[W-1],M}. sum = {A[W-1],A} ± addend. Then {X,A,B} ← {sum[W], sum[W:0], B[W-1:1]}, an arithmetic shift.
  - Unsigned mode: sum = {0,A} + (B[0] ? {0,M} : 0). Then {X,A,B} ← {0, sum[W:0], B[W-1:1]}, a logical shift carrying the adder's carry into A.
  - Then cnt←cnt+1.
- Result: {A,B} = product of the original B and M, modulo nothing. The full 2·WIDTH bits are exact in both modes.
- ClearA_LoadB is honoured only in IDLE and ignored in COMPUTE and DONE. If it is asserted together with Run in IDLE, load wins and there is no start. If Run is still high on the next edge, the start occurs then.
- Run held high in DONE does not restart. A new operation requires Run=0 (return to IDLE) and then Run=1.
- SignedMode and S changes during COMPUTE have no effect on the current operation.
- Reset (asynchronous, any state, including mid-COMPUTE): FSM←IDLE; A, B, M, X, cnt, mode ← 0; Busy=Done=0. Reset takes priority over all inputs.

## Timing
- Reset values: Aval=0, Bval=0, X=0, Busy=0, Done=0.
- Latency is counted in edges:
  - edge 0 samples Run=1 in IDLE and captures M;
  - edges 1..WIDTH perform the iterations;
  - Done=1 and the final product are visible after edge WIDTH+1, when the FSM enters DONE.
  - For WIDTH=8: Busy is high for 8 cycles and Done rises 9 edges after the start edge.
- Outputs are registered, with no combinational path from inputs to outputs. Aval/Bval show intermediate values during COMPUTE.
- Load latency: Bval=S is visible after the single edge that samples ClearA_LoadB=1 in IDLE.
- Done drops on the first edge after Run=0 is sampled in DONE.

## Test plan
- WIDTH=8, signed:
  - load 7, start with 59 → Aval=0x01, Bval=0x9D, X=0.
  - load 7, start with −59 (0xC5) → Aval=0xFE, Bval=0x63, X=1.
  - load −7 (0xF9), start with −59 → Aval=0x01, Bval=0x9D.
- WIDTH=8, unsigned: load 0xF9, start with 0xC5 → Aval=0xBF, Bval=0x9D, X=0. Signed corner: load 0x80, start with 0x80 → Aval=0x40, Bval=0x00.
- Chain, WIDTH=8 signed: load −2, then Run four times with S=0xFE (each Run preceded by Run=0) → Aval=0xFF, Bval=0xE0, X=1.
- WIDTH=16 signed: load 300, start with −5 → {Aval,Bval}=0xFFFFFA24. Check that Done rises exactly 17 edges after the start edge and Busy is high for exactly 16 cycles.
- Protocol:
  - Run held high in DONE → no restart and outputs stable.
  - ClearA_LoadB and Run asserted in the same IDLE cycle → B loaded, no start.
  - Changing S and SignedMode mid-COMPUTE → result unchanged.
- Reset asserted at iteration 4 of 8 (asynchronously, between edges) → all outputs are 0 immediately, FSM is in IDLE, and the next load+run gives the correct product.
